// File: rtl/axi_sram_bridge_mo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_sram_bridge_mo
// Brief    : SRAM-like inst/data ports to AXI3 bridge, multiple outstanding
//            reads per master, one write in flight.
// Revision : 1.0 - initial release
// ============================================================================
module axi_sram_bridge_mo #(
    parameter int         MAX_OUT = 2,
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        aclk,
    input  logic        aresetn,
    // instruction port
    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    // data port
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_strb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    // AR
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // R
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // AW
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    // W
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // B
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam int             c_CW  = $clog2(MAX_OUT + 1);
    localparam logic [c_CW:0]  c_MAX = (c_CW + 1)'(MAX_OUT);

    function automatic logic [2:0] f_strb_size(input logic [3:0] strb);
        case (strb)
            4'b1111:          f_strb_size = 3'd2;
            4'b0011, 4'b1100: f_strb_size = 3'd1;
            default:          f_strb_size = 3'd0;
        endcase
    endfunction

    logic             r_ar_valid;
    logic [3:0]       r_ar_id;
    logic [31:0]      r_ar_addr;
    logic [2:0]       r_ar_size;
    logic [c_CW-1:0]  r_ocnt_i;
    logic [c_CW-1:0]  r_ocnt_d;
    logic             r_wr_pend;
    logic             r_aw_valid;
    logic             r_w_valid;
    logic [31:0]      r_wr_addr;
    logic [31:0]      r_wr_data;
    logic [3:0]       r_wr_strb;
    logic [2:0]       r_wr_size;

    logic             w_ar_hs;
    logic             w_ar_free;
    logic             w_reg_i;
    logic             w_reg_d;
    logic [c_CW:0]    w_eff_i;
    logic [c_CW:0]    w_eff_d;
    logic             w_rd_blk;
    logic             w_data_rd_ok;
    logic             w_data_wr_ok;
    logic             w_inst_ok;
    logic             w_r_inst;
    logic             w_r_data;
    logic             w_inc_i, w_dec_i, w_inc_d, w_dec_d;
    logic             w_unused_resp;

    assign w_unused_resp = ^{rresp, bresp, bid};

    assign w_ar_hs   = r_ar_valid && arready;
    assign w_ar_free = !r_ar_valid || arready;
    assign w_reg_i   = r_ar_valid && (r_ar_id == INST_ID);
    assign w_reg_d   = r_ar_valid && (r_ar_id == DATA_ID);

    // Outstanding count includes the request still sitting in the AR register.
    assign w_eff_i = {1'b0, r_ocnt_i} + {{c_CW{1'b0}}, w_reg_i};
    assign w_eff_d = {1'b0, r_ocnt_d} + {{c_CW{1'b0}}, w_reg_d};

    assign w_rd_blk     = r_wr_pend && (data_addr[31:2] == r_wr_addr[31:2]);
    assign w_data_rd_ok = data_req && !data_wr && w_ar_free && (w_eff_d < c_MAX) && !w_rd_blk;
    assign w_data_wr_ok = data_req && data_wr && !r_wr_pend && (r_ocnt_d == '0) && !w_reg_d;
    assign w_inst_ok    = inst_req && !w_data_rd_ok && w_ar_free && (w_eff_i < c_MAX);

    assign w_r_inst = rvalid && (rid == INST_ID);
    assign w_r_data = rvalid && (rid == DATA_ID);

    assign w_inc_i = w_ar_hs && (r_ar_id == INST_ID);
    assign w_inc_d = w_ar_hs && (r_ar_id == DATA_ID);
    assign w_dec_i = w_r_inst && rlast;
    assign w_dec_d = w_r_data && rlast;

    // Request-side handshakes are masked while reset is held.
    assign inst_addr_ok = aresetn && w_inst_ok;
    assign data_addr_ok = aresetn && (w_data_rd_ok || w_data_wr_ok);
    assign inst_data_ok = aresetn && w_r_inst;
    assign data_data_ok = aresetn && (w_r_data || (bvalid && bready));
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign rready = 1'b1;
    assign bready = !w_r_data;

    assign arid    = r_ar_id;
    assign araddr  = r_ar_addr;
    assign arsize  = r_ar_size;
    assign arvalid = r_ar_valid;
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    assign awid    = DATA_ID;
    assign awaddr  = r_wr_addr;
    assign awsize  = r_wr_size;
    assign awvalid = r_aw_valid;
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;

    assign wid    = DATA_ID;
    assign wdata  = r_wr_data;
    assign wstrb  = r_wr_strb;
    assign wlast  = 1'b1;
    assign wvalid = r_w_valid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ar_valid <= 1'b0;
            r_ar_id    <= '0;
            r_ar_addr  <= '0;
            r_ar_size  <= '0;
        end else if (w_data_rd_ok) begin
            r_ar_valid <= 1'b1;
            r_ar_id    <= DATA_ID;
            r_ar_addr  <= data_addr;
            r_ar_size  <= f_strb_size(data_strb);
        end else if (w_inst_ok) begin
            r_ar_valid <= 1'b1;
            r_ar_id    <= INST_ID;
            r_ar_addr  <= inst_addr;
            r_ar_size  <= {1'b0, inst_size};
        end else if (arready) begin
            r_ar_valid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ocnt_i <= '0;
            r_ocnt_d <= '0;
        end else begin
            if (w_inc_i && !w_dec_i)
                r_ocnt_i <= r_ocnt_i + c_CW'(1);
            else if (w_dec_i && !w_inc_i)
                r_ocnt_i <= r_ocnt_i - c_CW'(1);
            if (w_inc_d && !w_dec_d)
                r_ocnt_d <= r_ocnt_d + c_CW'(1);
            else if (w_dec_d && !w_inc_d)
                r_ocnt_d <= r_ocnt_d - c_CW'(1);
        end
    end

    // AW and W retire independently; the write stays pending until B.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_pend  <= 1'b0;
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_strb  <= '0;
            r_wr_size  <= '0;
        end else if (w_data_wr_ok) begin
            r_wr_pend  <= 1'b1;
            r_aw_valid <= 1'b1;
            r_w_valid  <= 1'b1;
            r_wr_addr  <= data_addr;
            r_wr_data  <= data_wdata;
            r_wr_strb  <= data_strb;
            r_wr_size  <= f_strb_size(data_strb);
        end else begin
            if (r_aw_valid && awready)
                r_aw_valid <= 1'b0;
            if (r_w_valid && wready)
                r_w_valid <= 1'b0;
            if (r_wr_pend && bvalid && bready)
                r_wr_pend <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_bridge_mo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_sram_bridge_mo
// Brief    : Scenario tasks plus a randomized run against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_sram_bridge_mo;

    localparam int         MAX_OUT = 2;
    localparam logic [3:0] INST_ID = 4'd0;
    localparam logic [3:0] DATA_ID = 4'd1;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic inst_req, data_req, data_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic [3:0]  data_strb;
    logic [31:0] inst_rdata, data_rdata;
    logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache, wstrb;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic arvalid, arready, rlast, rvalid, rready;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [2:0]  size;
    } req_t;

    always #5 aclk = ~aclk;

    axi_sram_bridge_mo #(.MAX_OUT(MAX_OUT), .INST_ID(INST_ID), .DATA_ID(DATA_ID)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_strb(data_strb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    function automatic logic [31:0] rfun(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h5A5A_1234;
    endfunction

    // Transfer size follows the number of enabled byte lanes.
    function automatic logic [2:0] exp_size(input logic [3:0] s);
        int n;
        n = $countones(s);
        return (n == 4) ? 3'd2 : ((n == 2) ? 3'd1 : 3'd0);
    endfunction

    task automatic idle_inputs();
        inst_req = 0; inst_size = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_strb = 0; data_addr = 0; data_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    endtask

    task automatic step();
        @(posedge aclk); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        aresetn = 0; inst_req = 1; data_req = 1; rvalid = 1; rid = DATA_ID; bvalid = 1;
        #2;
        total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid got=%b exp=0", arvalid); end
        total++; if (awvalid !== 1'b0 || wvalid !== 1'b0) begin bad++; $display("FAIL rst_wr_valid got=%b%b exp=00", awvalid, wvalid); end
        total++; if (inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin bad++; $display("FAIL rst_addr_ok got=%b%b exp=00", inst_addr_ok, data_addr_ok); end
        total++; if (data_data_ok !== 1'b0 || inst_data_ok !== 1'b0) begin bad++; $display("FAIL rst_data_ok got=%b%b exp=00", inst_data_ok, data_data_ok); end
        idle_inputs();
        step();
        aresetn = 1;
        step();
    endtask

    task automatic test_outstanding();
        int n;
        idle_inputs();
        arready = 1; inst_req = 1; inst_size = 2'd2; inst_addr = 32'h1000;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge aclk);
            if (inst_addr_ok) n++;
            step();
        end
        total++; if (n != 2) begin bad++; $display("FAIL out_count got=%0d exp=2", n); end
        rvalid = 1; rid = INST_ID; rlast = 1; rdata = rfun(32'h1000);
        @(negedge aclk);
        total++; if (inst_data_ok !== 1'b1 || inst_rdata !== rfun(32'h1000)) begin bad++; $display("FAIL out_resp got=%b %h exp=1 %h", inst_data_ok, inst_rdata, rfun(32'h1000)); end
        total++; if (inst_addr_ok !== 1'b0) begin bad++; $display("FAIL out_still_stall got=%b exp=0", inst_addr_ok); end
        step();
        rvalid = 0;
        @(negedge aclk);
        total++; if (inst_addr_ok !== 1'b1) begin bad++; $display("FAIL out_third_accept got=%b exp=1", inst_addr_ok); end
        step();
        inst_req = 0;
        @(negedge aclk);
        total++; if (arvalid !== 1'b1 || arid !== INST_ID || arsize !== 3'd2 || araddr !== 32'h1000) begin bad++; $display("FAIL out_ar got=%b %h %h %h exp=1 %h 2 1000", arvalid, arid, arsize, araddr, INST_ID); end
        step();
        rvalid = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge aclk);
            total++; if (inst_data_ok !== 1'b1) begin bad++; $display("FAIL out_drain%0d got=%b exp=1", c, inst_data_ok); end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_priority();
        idle_inputs();
        arready = 1;
        inst_req = 1; inst_addr = 32'h2000; inst_size = 2'd1;
        data_req = 1; data_wr = 0; data_addr = 32'h40; data_strb = 4'b1100;
        @(negedge aclk);
        total++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin bad++; $display("FAIL prio_grant got d=%b i=%b exp d=1 i=0", data_addr_ok, inst_addr_ok); end
        step();
        data_req = 0;
        @(negedge aclk);
        total++; if (arvalid !== 1'b1 || arid !== DATA_ID || araddr !== 32'h40 || arsize !== 3'd1) begin bad++; $display("FAIL prio_ar_data got=%b %h %h %h exp=1 %h 40 1", arvalid, arid, araddr, arsize, DATA_ID); end
        total++; if (inst_addr_ok !== 1'b1) begin bad++; $display("FAIL prio_inst_after got=%b exp=1", inst_addr_ok); end
        step();
        inst_req = 0;
        @(negedge aclk);
        total++; if (arvalid !== 1'b1 || arid !== INST_ID || araddr !== 32'h2000 || arsize !== 3'd1) begin bad++; $display("FAIL prio_ar_inst got=%b %h %h %h exp=1 %h 2000 1", arvalid, arid, araddr, arsize, INST_ID); end
        step();
        arready = 0; rvalid = 1; rlast = 1; rid = DATA_ID; rdata = rfun(32'h40);
        @(negedge aclk);
        total++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || data_rdata !== rfun(32'h40)) begin bad++; $display("FAIL prio_rd_data got=%b %b %h exp=1 0 %h", data_data_ok, inst_data_ok, data_rdata, rfun(32'h40)); end
        step();
        rid = INST_ID; rdata = rfun(32'h2000);
        @(negedge aclk);
        total++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== rfun(32'h2000)) begin bad++; $display("FAIL prio_rd_inst got=%b %b %h exp=1 0 %h", inst_data_ok, data_data_ok, inst_rdata, rfun(32'h2000)); end
        step();
        idle_inputs();
    endtask

    task automatic test_write();
        int aw_n, w_n;
        idle_inputs();
        wready = 1;
        data_req = 1; data_wr = 1; data_addr = 32'h100; data_strb = 4'b0011; data_wdata = 32'hCAFE_0102;
        @(negedge aclk);
        total++; if (data_addr_ok !== 1'b1) begin bad++; $display("FAIL wr_accept got=%b exp=1", data_addr_ok); end
        step();
        data_req = 0;
        aw_n = 0; w_n = 0;
        for (int c = 0; c < 6; c++) begin
            awready = (c == 3);
            @(negedge aclk);
            if (awvalid) aw_n++;
            if (wvalid) w_n++;
            if (c == 0) begin
                total++; if (awsize !== 3'd1 || awaddr !== 32'h100 || awid !== DATA_ID) begin bad++; $display("FAIL wr_aw got=%h %h %h exp=1 100 %h", awsize, awaddr, awid, DATA_ID); end
                total++; if (wdata !== 32'hCAFE_0102 || wstrb !== 4'b0011 || wlast !== 1'b1 || wid !== DATA_ID) begin bad++; $display("FAIL wr_w got=%h %b %b %h", wdata, wstrb, wlast, wid); end
            end
            step();
        end
        total++; if (aw_n != 4 || w_n != 1) begin bad++; $display("FAIL wr_valid_len got aw=%0d w=%0d exp aw=4 w=1", aw_n, w_n); end
        awready = 0; bvalid = 1;
        @(negedge aclk);
        total++; if (data_data_ok !== 1'b1 || bready !== 1'b1) begin bad++; $display("FAIL wr_b got=%b %b exp=1 1", data_data_ok, bready); end
        step();
        bvalid = 0;
        @(negedge aclk);
        total++; if (data_data_ok !== 1'b0) begin bad++; $display("FAIL wr_b_once got=%b exp=0", data_data_ok); end
        step();
        idle_inputs();
    endtask

    task automatic test_read_block();
        idle_inputs();
        awready = 1; wready = 1; arready = 1;
        data_req = 1; data_wr = 1; data_addr = 32'h100; data_strb = 4'b1111; data_wdata = 32'h1234_5678;
        @(negedge aclk);
        total++; if (data_addr_ok !== 1'b1) begin bad++; $display("FAIL blk_wr_accept got=%b exp=1", data_addr_ok); end
        step();
        data_req = 0;
        step();
        data_req = 1; data_wr = 0; data_addr = 32'h102; data_strb = 4'b0100;
        @(negedge aclk);
        total++; if (data_addr_ok !== 1'b0) begin bad++; $display("FAIL blk_same_word got=%b exp=0", data_addr_ok); end
        step();
        data_addr = 32'h200; data_strb = 4'b1111;
        @(negedge aclk);
        total++; if (data_addr_ok !== 1'b1) begin bad++; $display("FAIL blk_other_word got=%b exp=1", data_addr_ok); end
        step();
        data_addr = 32'h102; data_strb = 4'b0100;
        @(negedge aclk);
        total++; if (data_addr_ok !== 1'b0) begin bad++; $display("FAIL blk_same_word2 got=%b exp=0", data_addr_ok); end
        step();
        bvalid = 1;
        @(negedge aclk);
        total++; if (data_data_ok !== 1'b1 || data_addr_ok !== 1'b0) begin bad++; $display("FAIL blk_b got ok=%b aok=%b exp 1 0", data_data_ok, data_addr_ok); end
        step();
        bvalid = 0;
        @(negedge aclk);
        total++; if (data_addr_ok !== 1'b1) begin bad++; $display("FAIL blk_release got=%b exp=1", data_addr_ok); end
        step();
        data_req = 0;
        @(negedge aclk);
        total++; if (arvalid !== 1'b1 || araddr !== 32'h102 || arsize !== 3'd0) begin bad++; $display("FAIL blk_ar got=%b %h %h exp=1 102 0", arvalid, araddr, arsize); end
        step();
        rvalid = 1; rlast = 1; rid = DATA_ID; rdata = rfun(32'h200);
        @(negedge aclk);
        total++; if (data_data_ok !== 1'b1 || data_rdata !== rfun(32'h200)) begin bad++; $display("FAIL blk_r0 got=%b %h exp=1 %h", data_data_ok, data_rdata, rfun(32'h200)); end
        step();
        rdata = rfun(32'h102);
        @(negedge aclk);
        total++; if (data_data_ok !== 1'b1 || data_rdata !== rfun(32'h102)) begin bad++; $display("FAIL blk_r1 got=%b %h exp=1 %h", data_data_ok, data_rdata, rfun(32'h102)); end
        step();
        idle_inputs();
    endtask

    task automatic test_collision();
        idle_inputs();
        awready = 1; wready = 1; arready = 1;
        data_req = 1; data_wr = 1; data_addr = 32'h300; data_strb = 4'b1000; data_wdata = 32'hABCD_0000;
        @(negedge aclk);
        total++; if (data_addr_ok !== 1'b1) begin bad++; $display("FAIL col_wr_accept got=%b exp=1", data_addr_ok); end
        step();
        data_wr = 0; data_addr = 32'h400; data_strb = 4'b1111;
        @(negedge aclk);
        total++; if (data_addr_ok !== 1'b1) begin bad++; $display("FAIL col_rd_accept got=%b exp=1", data_addr_ok); end
        step();
        data_req = 0;
        step();
        rvalid = 1; rlast = 1; rid = DATA_ID; rdata = rfun(32'h400); bvalid = 1;
        @(negedge aclk);
        total++; if (bready !== 1'b0 || data_data_ok !== 1'b1 || data_rdata !== rfun(32'h400)) begin bad++; $display("FAIL col_same got bready=%b ok=%b %h exp 0 1 %h", bready, data_data_ok, data_rdata, rfun(32'h400)); end
        step();
        rvalid = 0;
        @(negedge aclk);
        total++; if (bready !== 1'b1 || data_data_ok !== 1'b1) begin bad++; $display("FAIL col_deferred got bready=%b ok=%b exp 1 1", bready, data_data_ok); end
        step();
        bvalid = 0;
        @(negedge aclk);
        total++; if (data_data_ok !== 1'b0) begin bad++; $display("FAIL col_done got=%b exp=0", data_data_ok); end
        step();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        int n;
        idle_inputs();
        arready = 1; inst_req = 1; inst_addr = 32'h5000; inst_size = 2'd2;
        step();
        step();
        inst_req = 0; arready = 0;
        @(negedge aclk);
        total++; if (arvalid !== 1'b1) begin bad++; $display("FAIL mid_pre_arvalid got=%b exp=1", arvalid); end
        aresetn = 0; inst_req = 1;
        #1;
        total++; if (arvalid !== 1'b0 || inst_addr_ok !== 1'b0) begin bad++; $display("FAIL mid_async got arvalid=%b aok=%b exp 0 0", arvalid, inst_addr_ok); end
        step();
        aresetn = 1; arready = 1;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge aclk);
            if (inst_addr_ok) n++;
            step();
        end
        total++; if (n != 2) begin bad++; $display("FAIL mid_after_release got=%0d exp=2", n); end
        idle_inputs();
        aresetn = 0;
        step();
        aresetn = 1;
        step();
    endtask

    task automatic test_random();
        req_t        issue_q[$];
        req_t        slv_q[$];
        logic [31:0] iexp_q[$];
        logic [31:0] dexp_q[$];
        logic [3:0]  strb_tab [6];
        req_t        r;
        int          oi, od;
        strb_tab = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b1000};
        oi = 0; od = 0;
        idle_inputs();
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (cyc < 400) begin
                inst_req  = ($urandom_range(0, 1) == 1);
                inst_addr = $urandom;
                inst_size = 2'($urandom_range(0, 2));
                data_req  = ($urandom_range(0, 1) == 1);
                data_addr = $urandom;
                data_strb = strb_tab[$urandom_range(0, 5)];
                arready   = ($urandom_range(0, 3) != 0);
            end else begin
                inst_req = 0; data_req = 0; arready = 1;
            end
            data_wr = 0;
            if (slv_q.size() > 0 && (cyc >= 400 || $urandom_range(0, 2) != 0)) begin
                rvalid = 1; rlast = 1; rid = slv_q[0].id; rdata = rfun(slv_q[0].addr);
            end else begin
                rvalid = 0; rlast = 0; rid = 4'($urandom_range(0, 15)); rdata = $urandom;
            end
            @(negedge aclk);
            if (inst_addr_ok || data_addr_ok) begin
                total++;
                if (inst_addr_ok && data_addr_ok) begin bad++; $display("FAIL rnd_dual_grant cyc=%0d got both exp one", cyc); end
            end
            if (data_addr_ok) begin
                r.id = DATA_ID; r.addr = data_addr; r.size = exp_size(data_strb);
                issue_q.push_back(r); dexp_q.push_back(rfun(data_addr)); od++;
            end else if (inst_addr_ok) begin
                r.id = INST_ID; r.addr = inst_addr; r.size = {1'b0, inst_size};
                issue_q.push_back(r); iexp_q.push_back(rfun(inst_addr)); oi++;
            end
            if (inst_addr_ok || data_addr_ok) begin
                total++;
                if (oi > MAX_OUT || od > MAX_OUT) begin bad++; $display("FAIL rnd_outstanding cyc=%0d got i=%0d d=%0d exp<=%0d", cyc, oi, od, MAX_OUT); end
            end
            if (rvalid) begin
                total++;
                if (slv_q[0].id == INST_ID) begin
                    if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || iexp_q.size() == 0 || inst_rdata !== iexp_q[0]) begin
                        bad++; $display("FAIL rnd_inst_resp cyc=%0d got ok=%b %h", cyc, inst_data_ok, inst_rdata);
                    end
                    if (iexp_q.size() > 0) void'(iexp_q.pop_front());
                    oi--;
                end else begin
                    if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || dexp_q.size() == 0 || data_rdata !== dexp_q[0]) begin
                        bad++; $display("FAIL rnd_data_resp cyc=%0d got ok=%b %h", cyc, data_data_ok, data_rdata);
                    end
                    if (dexp_q.size() > 0) void'(dexp_q.pop_front());
                    od--;
                end
                void'(slv_q.pop_front());
            end
            if (arvalid && arready) begin
                total++;
                if (issue_q.size() == 0) begin
                    bad++; $display("FAIL rnd_ar_spurious cyc=%0d got id=%h addr=%h exp none", cyc, arid, araddr);
                end else begin
                    if (arid !== issue_q[0].id || araddr !== issue_q[0].addr || arsize !== issue_q[0].size) begin
                        bad++; $display("FAIL rnd_ar cyc=%0d got %h %h %h exp %h %h %h", cyc, arid, araddr, arsize, issue_q[0].id, issue_q[0].addr, issue_q[0].size);
                    end
                    slv_q.push_back(issue_q.pop_front());
                end
            end
            step();
        end
        total++;
        if (issue_q.size() != 0 || slv_q.size() != 0 || iexp_q.size() != 0 || dexp_q.size() != 0) begin
            bad++; $display("FAIL rnd_drain got q=%0d/%0d/%0d/%0d exp empty", issue_q.size(), slv_q.size(), iexp_q.size(), dexp_q.size());
        end
        idle_inputs();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_outstanding();
        test_priority();
        test_write();
        test_read_block();
        test_collision();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
